// File: rtl/life_grid_datapath.sv
// Conway life datapath: cell grid registers, coordinate toggling, generation stepping and VGA scan-out.
// Optional macro LIFE_WRAP_EN selects a toroidal grid; undefined gives a hard dead boundary.
module life_grid_datapath #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int GEN_DIV = 4,
    parameter int MAX_GEN = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ldX,
    input  logic       ldY,
    input  logic       load,
    input  logic       start,
    input  logic [7:0] loadVal,
    output logic       stop,
    output logic       plot,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       busy,
    output logic [15:0] gen_count
);
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int CW    = XW + YW;
    localparam int CELLS = GRID_W * GRID_H;
    localparam int DW    = $clog2(GEN_DIV) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PLOT_ONE, S_WAIT_TICK, S_STEP, S_SCAN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CELLS-1:0]  grid_q, grid_d, next_grid;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [DW-1:0]     div_q, div_d;
    logic [CW-1:0]     scan_q, scan_d;
    logic [15:0]       gen_q, gen_d;
    logic              changed_q, changed_d, empty_q, empty_d;
    logic [CW-1:0]     sel_idx;
    logic              halt;

    function automatic logic [CW-1:0] cell_idx(input int x, input int y);
        return CW'(y * GRID_W + x);
    endfunction

    function automatic logic [3:0] nbr_count(input logic [CELLS-1:0] g, input int x, input int y);
        logic [3:0] n;
        int nx, ny;
        n = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
`ifdef LIFE_WRAP_EN
                    nx = (x + dx + GRID_W) % GRID_W;
                    ny = (y + dy + GRID_H) % GRID_H;
                    n  = n + 4'(g[cell_idx(nx, ny)]);
`else
                    nx = x + dx;
                    ny = y + dy;
                    if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
                        n = n + 4'(g[cell_idx(nx, ny)]);
`endif
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        next_grid = '0;
        for (int y = 0; y < GRID_H; y++) begin
            for (int x = 0; x < GRID_W; x++) begin
                next_grid[cell_idx(x, y)] = (nbr_count(grid_q, x, y) == 4'd3) ||
                    (grid_q[cell_idx(x, y)] && nbr_count(grid_q, x, y) == 4'd2);
            end
        end
    end

    assign sel_idx = {y_q, x_q};
    // gen_q already includes the step just taken when the scan finishes.
    assign halt = !changed_q || empty_q || (MAX_GEN != 0 && gen_q >= 16'(MAX_GEN));

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        x_d       = ldX ? loadVal[XW-1:0] : x_q;
        y_d       = ldY ? loadVal[YW-1:0] : y_q;
        div_d     = div_q;
        scan_d    = scan_q;
        gen_d     = gen_q;
        changed_d = changed_q;
        empty_d   = empty_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    grid_d[sel_idx] = ~grid_q[sel_idx];
                    state_d         = S_PLOT_ONE;
                end else if (start) begin
                    div_d   = '0;
                    state_d = S_WAIT_TICK;
                end
            end
            S_PLOT_ONE: state_d = S_IDLE;
            S_WAIT_TICK: begin
                if (!start)                          state_d = S_IDLE;
                else if (div_q == DW'(GEN_DIV - 1))  state_d = S_STEP;
                else                                 div_d   = div_q + 1'b1;
            end
            S_STEP: begin
                grid_d    = next_grid;
                changed_d = (next_grid != grid_q);
                empty_d   = (next_grid == '0);
                gen_d     = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
                scan_d    = '0;
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                if (scan_q == CW'(CELLS - 1)) begin
                    if (halt)       state_d = S_DONE;
                    else if (start) begin
                        div_d   = '0;
                        state_d = S_WAIT_TICK;
                    end else        state_d = S_IDLE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset forces them low asynchronously.
    always_comb begin
        plot   = 1'b0;
        x_out  = '0;
        y_out  = '0;
        colour = '0;
        case (state_q)
            S_PLOT_ONE: begin
                plot   = 1'b1;
                x_out  = 8'(x_q);
                y_out  = 7'(y_q);
                colour = {3{grid_q[sel_idx]}};
            end
            S_SCAN: begin
                plot   = 1'b1;
                x_out  = 8'(scan_q[XW-1:0]);
                y_out  = 7'(scan_q[CW-1:XW]);
                colour = {3{grid_q[scan_q]}};
            end
            default: ;
        endcase
    end

    assign stop      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign gen_count = gen_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grid_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            div_q     <= '0;
            scan_q    <= '0;
            gen_q     <= '0;
            changed_q <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            div_q     <= div_d;
            scan_q    <= scan_d;
            gen_q     <= gen_d;
            changed_q <= changed_d;
            empty_q   <= empty_d;
        end
    end
endmodule

// File: tb/tb_life_grid_datapath.sv
// Directed bench for life_grid_datapath: toggles, blinker, block, edge wrap, mid-scan reset.
module tb_life_grid_datapath;
    logic        clock, reset, ldX, ldY, load, start;
    logic [7:0]  loadVal;
    logic        stop, plot, busy;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour;
    logic [15:0] gen_count;

    int n_tests = 0;
    int n_fail  = 0;
    int load_at = -1;
    logic [255:0] exp_grid;
    logic [2:0]   exp_q[$];

    life_grid_datapath dut (
        .clock(clock), .reset(reset), .ldX(ldX), .ldY(ldY), .load(load),
        .start(start), .loadVal(loadVal), .stop(stop), .plot(plot),
        .x_out(x_out), .y_out(y_out), .colour(colour), .busy(busy),
        .gen_count(gen_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_stop"}, stop, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_x"}, x_out, 0);
        check({tag, "_y"}, y_out, 0);
        check({tag, "_colour"}, colour, 0);
        check({tag, "_gen"}, gen_count, 0);
    endtask

    task automatic do_reset();
        start = 0; load = 0; ldX = 0; ldY = 0; loadVal = 0;
        reset = 1;
        #1;
        check_quiet("reset");
        tick();
        reset = 0;
        tick();
        check_quiet("post_reset");
    endtask

    task automatic toggle(input logic [7:0] lx, input logic [7:0] ly,
                          input logic [7:0] ex, input logic [6:0] ey, input logic [2:0] ecol);
        ldX = 1; loadVal = lx; tick(); ldX = 0;
        ldY = 1; loadVal = ly; tick(); ldY = 0;
        load = 1; tick(); load = 0;
        check("toggle_plot", plot, 1);
        check("toggle_x", x_out, ex);
        check("toggle_y", y_out, ey);
        check("toggle_colour", colour, ecol);
        tick();
        check("toggle_idle_plot", plot, 0);
        check("toggle_idle_busy", busy, 0);
    endtask

    task automatic put(input int x, input int y);
        exp_grid[y * 16 + x] = 1'b1;
    endtask

    task automatic run_gen(input int exp_lat, input int exp_gen, input bit exp_halt);
        int lat;
        start = 1;
        lat = 0;
        while (!plot && lat < 40) begin
            tick();
            lat++;
        end
        check("scan_latency", lat, exp_lat);
        check("gen_count", gen_count, exp_gen);
        for (int i = 0; i < 256; i++) exp_q.push_back(exp_grid[i] ? 3'b111 : 3'b000);
        for (int i = 0; i < 256; i++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            if (!plot) check("scan_plot", plot, 1);
            if (x_out !== 8'(i % 16)) check("scan_x", x_out, i % 16);
            if (y_out !== 7'(i / 16)) check("scan_y", y_out, i / 16);
            check("scan_colour", colour, e);
            if (i == load_at) load = 1;
            tick();
            load = 0;
        end
        if (exp_halt) begin
            check("stop_pulse", stop, 1);
            start = 0;
            tick();
            check("stop_low", stop, 0);
            check("busy_after_stop", busy, 0);
        end else begin
            check("no_stop", stop, 0);
            check("busy_continue", busy, 1);
        end
    endtask

    initial begin
        reset = 1; start = 0; load = 0; ldX = 0; ldY = 0; loadVal = 0;

        // Reset, then an empty grid steps, scans black and halts.
        do_reset();
        exp_grid = '0;
        run_gen(6, 1, 1);

        // Single-cell toggles and coordinate truncation.
        toggle(3, 5, 3, 5, 3'b111);
        toggle(3, 5, 3, 5, 3'b000);
        toggle(19, 5, 3, 5, 3'b111);
        toggle(3, 5, 3, 5, 3'b000);

        // Blinker oscillates; never stops.
        do_reset();
        toggle(4, 5, 4, 5, 3'b111);
        toggle(5, 5, 5, 5, 3'b111);
        toggle(6, 5, 6, 5, 3'b111);
        exp_grid = '0; put(5, 4); put(5, 5); put(5, 6);
        run_gen(6, 1, 0);
        exp_grid = '0; put(4, 5); put(5, 5); put(6, 5);
        run_gen(5, 2, 0);
        start = 0;
        tick();
        check("blinker_abort_busy", busy, 0);
        check("blinker_abort_gen", gen_count, 2);

        // Still-life block halts after one generation; load mid-scan is ignored.
        do_reset();
        toggle(2, 2, 2, 2, 3'b111);
        toggle(3, 2, 3, 2, 3'b111);
        toggle(2, 3, 2, 3, 3'b111);
        toggle(3, 3, 3, 3, 3'b111);
        exp_grid = '0; put(2, 2); put(3, 2); put(2, 3); put(3, 3);
        load_at = 50;
        run_gen(6, 1, 1);
        load_at = -1;
        run_gen(6, 2, 1);

        // Row of three straddling the left/right edge.
        do_reset();
        toggle(15, 7, 15, 7, 3'b111);
        toggle(0, 7, 0, 7, 3'b111);
        toggle(1, 7, 1, 7, 3'b111);
`ifdef LIFE_WRAP_EN
        exp_grid = '0; put(0, 6); put(0, 7); put(0, 8);
        run_gen(6, 1, 0);
        start = 0;
        tick();
        check("wrap_idle_busy", busy, 0);
`else
        exp_grid = '0;
        run_gen(6, 1, 1);
`endif

        // Reset mid-scan at cell 100.
        do_reset();
        toggle(4, 5, 4, 5, 3'b111);
        toggle(5, 5, 5, 5, 3'b111);
        toggle(6, 5, 6, 5, 3'b111);
        start = 1;
        begin
            int lat;
            lat = 0;
            while (!plot && lat < 40) begin
                tick();
                lat++;
            end
            check("midreset_latency", lat, 6);
        end
        for (int i = 0; i < 100; i++) tick();
        check("midreset_x", x_out, 4);
        check("midreset_y", y_out, 6);
        check("midreset_plot_before", plot, 1);
        reset = 1;
        #1;
        check_quiet("midreset");
        start = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midreset_no_stop", stop, 0);
        end
        exp_grid = '0;
        run_gen(6, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
